spi_slave_rx: RTL and testbench
===============================

// Module: spi_slave_rx
// PURPOSE
//  SPI peripheral-side receiver, the counterpart to our SPI master transmitter.
//  Oversamples SCK/MOSI/CS in the system CLK domain and deserialises MSB-first
//  WORD_W-bit words (CS active-high, MOSI sampled on SCK rising edge).
//  Presents each word on DATA with a VALID/ACK hold handshake to downstream logic,
//  e.g. a DAC/codec register loader or a second board.
// PARAMETERS
//  WORD_W       8   bits per word; must be >= 2
//  SYNC_STAGES  2   flops per input synchroniser; must be >= 2
// PORTS
//  CLK        in   1       system clock; all state on rising edge
//  RESET      in   1       asynchronous, active-high reset
//  SCK        in   1       serial clock from master (async to CLK)
//  MOSI       in   1       serial data from master (async to CLK)
//  CS         in   1       chip select, active-high (frame open while 1)
//  DATA       out  WORD_W  last complete received word
//  VALID      out  1       DATA holds an unacknowledged word
//  ACK        in   1       consumer takes DATA; clears VALID
//  OVERRUN    out  1       1-cycle pulse: new word overwrote unacked word
//  FRAME_ERR  out  1       1-cycle pulse: CS fell with partial word
// BEHAVIOUR
//  - Reset (async assert, sync release): DATA=0, VALID=0, OVERRUN=0, FRAME_ERR=0,
//    shift reg=0, bit count=0, state IDLE, all synchroniser flops=0.
//  - SCK, MOSI and CS each pass through SYNC_STAGES flops. Edges are detected by
//    comparing the sync output with one extra registered copy.
//  - Input timing: each SCK high and low phase lasts >= 2 CLK periods. MOSI is stable
//    around the SCK rise. Faster SCK is out of spec and has no defined result.
//  - FSM:
//    - IDLE: stay while cs_s=0; bit count held at 0. cs_s rise -> SHIFT.
//    - SHIFT: on each sck_s rising edge, shift = {shift[W-2:0], mosi_s}; cnt += 1.
//    - When cnt = WORD_W-1 at an edge: DATA <= assembled word; VALID <= 1; cnt <= 0.
//      Stay in SHIFT, so back-to-back words in one frame are supported.
//    - cs_s fall in SHIFT -> IDLE. If cnt != 0, pulse FRAME_ERR and discard the
//      partial word. DATA and VALID are untouched.
//  - SCK edges while cs_s=0 are ignored.
//  - Latency: VALID rises SYNC_STAGES+1 CLK cycles after the CLK edge that first
//    captures the final SCK rise.
//  - Handshake: VALID stays 1 until a cycle with ACK=1, then clears on the next edge.
//    ACK while VALID=0 is ignored.
//  - New word in the same cycle as ACK: new word loads, VALID stays 1, no OVERRUN.
//  - New word with VALID=1 and ACK=0: DATA overwritten, VALID stays 1, OVERRUN pulses.
//  - RESET mid-frame: partial word lost. After release, the block waits in IDLE for
//    a fresh cs_s rise even if CS is already high (no mid-frame resync).
// CONFIGURATION
//  SPI_RX_MISO_EN defined:
//    - Adds ports TX_DATA (in, WORD_W) and MISO (out, 1).
//    - TX_DATA is loaded into a tx shift register on cs_s rise and at each word
//      boundary.
//    - MISO drives the tx MSB and advances on each sck_s falling edge in SHIFT.
//    - MISO=0 in IDLE and in reset.
//  SPI_RX_MISO_EN undefined: TX_DATA/MISO ports and tx logic absent; receive path
//    is identical.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE, SHIFT), default WORD_W and SYNC_STAGES
//    constants, bit-count width derived as $clog2(WORD_W).
//  - Sub-module: spi_sync, a parameterised SYNC_STAGES-deep 1-bit synchroniser with
//    async reset to 0. It is instantiated three times (SCK, MOSI, CS).
// TESTING
//  - Reset: assert RESET mid-word (4 bits in) -> all outputs 0. A new frame after
//    release of 8'hA5 -> DATA=8'hA5, VALID=1.
//  - Single word: CS=1, send 8'h3C with SCK period 8 CLK, then ACK one cycle later
//    -> VALID rises SYNC_STAGES+1 cycles after the 8th SCK rise; VALID=0 after ACK.
//  - Burst: one frame with 8'h01, 8'hFF, 8'h80, ACK each word -> three VALID
//    assertions with matching DATA, no OVERRUN.
//  - Overrun: send 8'h11 then 8'h22 with no ACK -> DATA=8'h22, OVERRUN pulses once.
//    Repeat with ACK landing on the same cycle the 2nd word loads -> no OVERRUN.
//  - Frame error: CS falls after 5 bits -> FRAME_ERR one-cycle pulse; DATA/VALID
//    unchanged; next full word 8'h5A received correctly.
//  - SPI_RX_MISO_EN: TX_DATA=8'hC3 and master sends 8'h00 -> master captures 8'hC3
//    on MISO; MISO=0 once CS falls.

Source files
------------

// File: rtl/spi_slave_rx_pkg.sv
// rtl/spi_slave_rx_pkg.sv - shared state encoding and sizing for the SPI slave receiver
package spi_slave_rx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEF_WORD_W      = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = $clog2(DEF_WORD_W);

  // Bit-counter width; WORD_W is at least 2 so this is always >= 1
  function automatic int cnt_width(input int word_w);
    return $clog2(word_w);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - multi-flop 1-bit synchroniser, async reset to 0
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_ff;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_ff <= '0;
    else       r_ff <= {r_ff[STAGES-2:0], i_d};
  end

  assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - oversampled SPI slave receiver; SPI_RX_MISO_EN adds the MISO transmit path
module spi_slave_rx
  import spi_slave_rx_pkg::*;
#(
  parameter int WORD_W      = DEF_WORD_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SCK,
  input  logic              MOSI,
  input  logic              CS,
  output logic [WORD_W-1:0] DATA,
  output logic              VALID,
  input  logic              ACK,
  output logic              OVERRUN,
  output logic              FRAME_ERR
`ifdef SPI_RX_MISO_EN
  ,
  input  logic [WORD_W-1:0] TX_DATA,
  output logic              MISO
`endif
);

  localparam int CNT_W = cnt_width(WORD_W);

  logic              w_sck_s, w_mosi_s, w_cs_s;
  logic              r_sck_d, r_cs_d, r_mosi_q;
  logic              r_sck_rise, r_cs_rise, r_cs_fall;
  logic [SYNC_STAGES:0] r_flush;
  logic              r_armed;
  state_t            r_state;
  logic [WORD_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sck  (.i_clk(CLK), .i_rst(RESET), .i_d(SCK),  .o_q(w_sck_s));
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (.i_clk(CLK), .i_rst(RESET), .i_d(MOSI), .o_q(w_mosi_s));
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs   (.i_clk(CLK), .i_rst(RESET), .i_d(CS),   .o_q(w_cs_s));

  // Edge strobes; CS rise is only honoured once a genuine CS low has been seen
  // after the synchronisers have flushed, so a reset mid-frame cannot resync
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_sck_d    <= 1'b0;
      r_cs_d     <= 1'b0;
      r_mosi_q   <= 1'b0;
      r_sck_rise <= 1'b0;
      r_cs_rise  <= 1'b0;
      r_cs_fall  <= 1'b0;
      r_flush    <= '0;
      r_armed    <= 1'b0;
    end else begin
      r_sck_d    <= w_sck_s;
      r_cs_d     <= w_cs_s;
      r_mosi_q   <= w_mosi_s;
      r_sck_rise <= w_sck_s & ~r_sck_d;
      r_cs_rise  <= w_cs_s & ~r_cs_d & r_armed;
      r_cs_fall  <= ~w_cs_s & r_cs_d;
      r_flush    <= {r_flush[SYNC_STAGES-1:0], 1'b1};
      if (r_flush[SYNC_STAGES] && !w_cs_s) r_armed <= 1'b1;
    end
  end

  // Frame FSM: deserialise words, run the VALID/ACK handshake, flag errors
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      DATA      <= '0;
      VALID     <= 1'b0;
      OVERRUN   <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      OVERRUN   <= 1'b0;
      FRAME_ERR <= 1'b0;
      if (ACK) VALID <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (r_cs_rise) r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (r_cs_fall) begin
            r_state <= ST_IDLE;
            if (r_cnt != '0) FRAME_ERR <= 1'b1;
            r_cnt   <= '0;
            r_shift <= '0;
          end else if (r_sck_rise) begin
            r_shift <= {r_shift[WORD_W-2:0], r_mosi_q};
            if (r_cnt == CNT_W'(WORD_W - 1)) begin
              DATA  <= {r_shift[WORD_W-2:0], r_mosi_q};
              VALID <= 1'b1;
              r_cnt <= '0;
              if (VALID && !ACK) OVERRUN <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_RX_MISO_EN
  logic              r_sck_fall;
  logic [WORD_W-1:0] r_tx;

  // Transmit shifter: load at frame open and on the first SCK fall of each
  // new word (counter back at 0), otherwise advance one bit per SCK fall
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_sck_fall <= 1'b0;
      r_tx       <= '0;
    end else begin
      r_sck_fall <= ~w_sck_s & r_sck_d;
      if (r_state == ST_IDLE) begin
        if (r_cs_rise) r_tx <= TX_DATA;
      end else if (r_sck_fall) begin
        if (r_cnt == '0) r_tx <= TX_DATA;
        else             r_tx <= {r_tx[WORD_W-2:0], 1'b0};
      end
    end
  end

  assign MISO = (r_state == ST_SHIFT) ? r_tx[WORD_W-1] : 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - directed self-checking bench for spi_slave_rx
module tb_spi_slave_rx;

  logic       CLK = 1'b0;
  logic       RESET, SCK, MOSI, CS, ACK;
  logic [7:0] DATA;
  logic       VALID, OVERRUN, FRAME_ERR;
`ifdef SPI_RX_MISO_EN
  logic [7:0] TX_DATA;
  logic       MISO;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_ovr    = 0;
  int n_ferr   = 0;
  int lat, o0, f0;
  logic [7:0] master_rx;
  logic [7:0] burst [3];

  spi_slave_rx #(.WORD_W(8), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RESET(RESET), .SCK(SCK), .MOSI(MOSI), .CS(CS),
    .DATA(DATA), .VALID(VALID), .ACK(ACK), .OVERRUN(OVERRUN), .FRAME_ERR(FRAME_ERR)
`ifdef SPI_RX_MISO_EN
    , .TX_DATA(TX_DATA), .MISO(MISO)
`endif
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (OVERRUN)   n_ovr  <= n_ovr + 1;
    if (FRAME_ERR) n_ferr <= n_ferr + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send the top n bits of w MSB-first, SCK period 8 CLK; optionally pulse ACK
  // so it is sampled on the same edge that loads the final word
  task automatic send_bits(input logic [7:0] w, input int n, input bit ack_at_load, output int l);
    logic prev_v;
    l = 0;
    prev_v = VALID;
    for (int i = 7; i > 7 - n; i--) begin
      MOSI = w[i];
      SCK  = 1'b0;
      repeat (4) @(negedge CLK);
      SCK = 1'b1;
`ifdef SPI_RX_MISO_EN
      master_rx = {master_rx[6:0], MISO};
`endif
      for (int k = 0; k < 4; k++) begin
        @(posedge CLK); #1;
        if (i == 0 && !prev_v && l == 0 && VALID) l = k;
        if (i == 0 && ack_at_load && k == 2) ACK = 1'b1;
        if (i == 0 && ack_at_load && k == 3) ACK = 1'b0;
        @(negedge CLK);
      end
    end
    SCK = 1'b0;
  endtask

  task automatic open_frame();
    CS = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic close_frame();
    CS = 1'b0;
    repeat (6) @(negedge CLK);
  endtask

  task automatic ack_word();
    @(negedge CLK); ACK = 1'b1;
    @(negedge CLK); ACK = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; SCK = 1'b0; MOSI = 1'b0; CS = 1'b0; ACK = 1'b0;
    master_rx = 8'h00;
`ifdef SPI_RX_MISO_EN
    TX_DATA = 8'h00;
`endif
    burst[0] = 8'h01; burst[1] = 8'hFF; burst[2] = 8'h80;
    repeat (3) @(negedge CLK);
    check("rst_data",  DATA,      8'h00);
    check("rst_valid", VALID,     1'b0);
    check("rst_ovr",   OVERRUN,   1'b0);
    check("rst_ferr",  FRAME_ERR, 1'b0);
    RESET = 1'b0;
    repeat (6) @(negedge CLK);

    // Reset in the middle of a word, CS kept high across the release
    open_frame();
    send_bits(8'hE7, 8, 1'b0, lat);
    check("pre_rst_data", DATA, 8'hE7);
    send_bits(8'hF0, 4, 1'b0, lat);
    RESET = 1'b1;
    @(negedge CLK);
    check("midrst_data",  DATA,  8'h00);
    check("midrst_valid", VALID, 1'b0);
    RESET = 1'b0;
    repeat (6) @(negedge CLK);
    send_bits(8'hFF, 8, 1'b0, lat);
    repeat (4) @(negedge CLK);
    check("noresync_valid", VALID, 1'b0);
    check("noresync_data",  DATA,  8'h00);
    close_frame();
    open_frame();
    send_bits(8'hA5, 8, 1'b0, lat);
    check("a5_data",  DATA,  8'hA5);
    check("a5_valid", VALID, 1'b1);
    close_frame();
    ack_word();

    // Single word, latency and ACK
    open_frame();
    send_bits(8'h3C, 8, 1'b0, lat);
    check("single_latency", lat,   3);
    check("single_data",    DATA,  8'h3C);
    check("single_valid",   VALID, 1'b1);
    ack_word();
    check("single_acked",   VALID, 1'b0);
    close_frame();

    // Burst of three words in one frame
    o0 = n_ovr;
    open_frame();
    for (int b = 0; b < 3; b++) begin
      send_bits(burst[b], 8, 1'b0, lat);
      check("burst_data",  DATA,  burst[b]);
      check("burst_valid", VALID, 1'b1);
      ack_word();
    end
    close_frame();
    check("burst_no_ovr", n_ovr - o0, 0);

    // Overrun, then ACK coinciding with the load
    o0 = n_ovr;
    open_frame();
    send_bits(8'h11, 8, 1'b0, lat);
    send_bits(8'h22, 8, 1'b0, lat);
    repeat (2) @(negedge CLK);
    check("ovr_data",  DATA,       8'h22);
    check("ovr_valid", VALID,      1'b1);
    check("ovr_count", n_ovr - o0, 1);
    ack_word();
    send_bits(8'h11, 8, 1'b0, lat);
    o0 = n_ovr;
    send_bits(8'h22, 8, 1'b1, lat);
    repeat (2) @(negedge CLK);
    check("ackload_data",  DATA,       8'h22);
    check("ackload_valid", VALID,      1'b1);
    check("ackload_novr",  n_ovr - o0, 0);
    ack_word();
    close_frame();

    // Frame error on a partial word
    f0 = n_ferr;
    open_frame();
    send_bits(8'h77, 8, 1'b0, lat);
    close_frame();
    check("clean_close_noferr", n_ferr - f0, 0);
    open_frame();
    send_bits(8'hFF, 5, 1'b0, lat);
    close_frame();
    check("ferr_count", n_ferr - f0, 1);
    check("ferr_data",  DATA,        8'h77);
    check("ferr_valid", VALID,       1'b1);
    ack_word();
    open_frame();
    send_bits(8'h5A, 8, 1'b0, lat);
    check("after_ferr_data",  DATA,  8'h5A);
    check("after_ferr_valid", VALID, 1'b1);
    close_frame();
    ack_word();

`ifdef SPI_RX_MISO_EN
    TX_DATA = 8'hC3;
    master_rx = 8'h00;
    open_frame();
    send_bits(8'h00, 8, 1'b0, lat);
    check("miso_word", master_rx, 8'hC3);
    check("miso_rxdata", DATA, 8'h00);
    close_frame();
    check("miso_idle", MISO, 1'b0);
    ack_word();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
